// File: rtl/mem_arbiter.sv
// Arbitrates one fixed-latency word memory between instruction fetch and load/store.
// Optional MEM_ARB_PERF_EN adds grant and conflict counters.
module mem_arbiter #(
    parameter int ADDR_W     = 12,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_valid_i,
    output logic              if_ready_o,
    input  logic [31:0]       if_addr_i,
    output logic              if_rsp_valid_o,
    output logic [31:0]       if_rsp_data_o,
    output logic              if_rsp_err_o,
    input  logic              ls_valid_i,
    output logic              ls_ready_o,
    input  logic              ls_we_i,
    input  logic [1:0]        ls_size_i,
    input  logic              ls_unsigned_i,
    input  logic [31:0]       ls_addr_i,
    input  logic [31:0]       ls_wdata_i,
    output logic              ls_rsp_valid_o,
    output logic [31:0]       ls_rsp_data_o,
    output logic              ls_rsp_err_o,
`ifdef MEM_ARB_PERF_EN
    output logic [31:0]       perf_if_cnt_o,
    output logic [31:0]       perf_ls_cnt_o,
    output logic [31:0]       perf_conflict_cnt_o,
`endif
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [3:0]        mem_be_o,
    output logic [ADDR_W-3:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i
);
    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam int LW = $clog2(MEM_LAT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state_q;
    logic [CW-1:0]     starve_q;
    logic [LW-1:0]     lat_q;
    logic              is_ls_q, we_q, uns_q, err_q;
    logic [1:0]        size_q, addr_lo_q;
    logic              mem_en_q, mem_we_q;
    logic [3:0]        mem_be_q;
    logic [ADDR_W-3:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic              if_rsp_valid_q, if_rsp_err_q, ls_rsp_valid_q, ls_rsp_err_q;
    logic [31:0]       if_rsp_data_q, ls_rsp_data_q;

    logic        force_if, grant_ls, grant_if;
    logic [31:0] sel_addr, req_wdata, shifted, load_ext;
    logic [1:0]  sel_size;
    logic        misal;
    logic [3:0]  req_be;
    logic        unused_hi;

    // LS wins unless IF has already lost STARVE_MAX arbitrations in a row.
    always_comb begin
        force_if = if_valid_i && (starve_q == CW'(STARVE_MAX));
        grant_ls = (state_q == IDLE) && ls_valid_i && !force_if;
        grant_if = (state_q == IDLE) && if_valid_i && !grant_ls;
        sel_addr = grant_ls ? ls_addr_i : if_addr_i;
        sel_size = grant_ls ? ls_size_i : 2'b10;
        case (sel_size)
            2'b00:   misal = 1'b0;
            2'b01:   misal = sel_addr[0];
            2'b10:   misal = (sel_addr[1:0] != 2'b00);
            default: misal = 1'b1;
        endcase
        req_be    = 4'b0000;
        req_wdata = 32'h0;
        if (grant_ls && ls_we_i) begin
            case (ls_size_i)
                2'b00: begin
                    req_be    = 4'b0001 << sel_addr[1:0];
                    req_wdata = {4{ls_wdata_i[7:0]}};
                end
                2'b01: begin
                    req_be    = sel_addr[1] ? 4'b1100 : 4'b0011;
                    req_wdata = {2{ls_wdata_i[15:0]}};
                end
                default: begin
                    req_be    = 4'b1111;
                    req_wdata = ls_wdata_i;
                end
            endcase
        end
    end

    assign unused_hi = ^sel_addr[31:ADDR_W];

    always_comb begin
        shifted = mem_rdata_i >> {addr_lo_q, 3'b000};
        case (size_q)
            2'b00:   load_ext = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
            2'b01:   load_ext = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
            default: load_ext = shifted;
        endcase
        if (we_q)
            load_ext = 32'h0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            starve_q       <= '0;
            lat_q          <= '0;
            is_ls_q        <= 1'b0;
            we_q           <= 1'b0;
            uns_q          <= 1'b0;
            err_q          <= 1'b0;
            size_q         <= 2'b00;
            addr_lo_q      <= 2'b00;
            mem_en_q       <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_be_q       <= 4'b0000;
            mem_addr_q     <= '0;
            mem_wdata_q    <= 32'h0;
            if_rsp_valid_q <= 1'b0;
            if_rsp_err_q   <= 1'b0;
            if_rsp_data_q  <= 32'h0;
            ls_rsp_valid_q <= 1'b0;
            ls_rsp_err_q   <= 1'b0;
            ls_rsp_data_q  <= 32'h0;
        end else begin
            if_rsp_valid_q <= 1'b0;
            if_rsp_err_q   <= 1'b0;
            if_rsp_data_q  <= 32'h0;
            ls_rsp_valid_q <= 1'b0;
            ls_rsp_err_q   <= 1'b0;
            ls_rsp_data_q  <= 32'h0;
            case (state_q)
                IDLE: begin
                    if (!if_valid_i || grant_if)
                        starve_q <= '0;
                    else if (grant_ls && starve_q != CW'(STARVE_MAX))
                        starve_q <= starve_q + CW'(1);
                    if (grant_ls || grant_if) begin
                        is_ls_q     <= grant_ls;
                        we_q        <= grant_ls && ls_we_i;
                        uns_q       <= grant_ls && ls_unsigned_i;
                        size_q      <= sel_size;
                        addr_lo_q   <= sel_addr[1:0];
                        err_q       <= misal;
                        mem_en_q    <= !misal;
                        mem_we_q    <= !misal && grant_ls && ls_we_i;
                        mem_be_q    <= misal ? 4'b0000 : req_be;
                        mem_addr_q  <= misal ? '0 : sel_addr[ADDR_W-1:2];
                        mem_wdata_q <= misal ? 32'h0 : req_wdata;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_en_q    <= 1'b0;
                    mem_we_q    <= 1'b0;
                    mem_be_q    <= 4'b0000;
                    mem_addr_q  <= '0;
                    mem_wdata_q <= 32'h0;
                    lat_q       <= '0;
                    if (err_q) begin
                        if_rsp_valid_q <= !is_ls_q;
                        if_rsp_err_q   <= !is_ls_q;
                        ls_rsp_valid_q <= is_ls_q;
                        ls_rsp_err_q   <= is_ls_q;
                        state_q        <= RESP;
                    end else begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (lat_q == LW'(MEM_LAT - 1)) begin
                        if_rsp_valid_q <= !is_ls_q;
                        if_rsp_data_q  <= is_ls_q ? 32'h0 : mem_rdata_i;
                        ls_rsp_valid_q <= is_ls_q;
                        ls_rsp_data_q  <= is_ls_q ? load_ext : 32'h0;
                        state_q        <= RESP;
                    end else begin
                        lat_q <= lat_q + LW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_if_q, perf_ls_q, perf_conf_q;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_if_q   <= 32'h0;
            perf_ls_q   <= 32'h0;
            perf_conf_q <= 32'h0;
        end else begin
            perf_if_q   <= perf_if_q + {31'h0, grant_if};
            perf_ls_q   <= perf_ls_q + {31'h0, grant_ls};
            perf_conf_q <= perf_conf_q + {31'h0, (state_q == IDLE) && if_valid_i && ls_valid_i};
        end
    end
    assign perf_if_cnt_o       = perf_if_q;
    assign perf_ls_cnt_o       = perf_ls_q;
    assign perf_conflict_cnt_o = perf_conf_q;
`endif

    assign if_ready_o     = grant_if;
    assign ls_ready_o     = grant_ls;
    assign mem_en_o       = mem_en_q;
    assign mem_we_o       = mem_we_q;
    assign mem_be_o       = mem_be_q;
    assign mem_addr_o     = mem_addr_q;
    assign mem_wdata_o    = mem_wdata_q;
    assign if_rsp_valid_o = if_rsp_valid_q;
    assign if_rsp_data_o  = if_rsp_data_q;
    assign if_rsp_err_o   = if_rsp_err_q;
    assign ls_rsp_valid_o = ls_rsp_valid_q;
    assign ls_rsp_data_o  = ls_rsp_data_q;
    assign ls_rsp_err_o   = ls_rsp_err_q;
endmodule
